// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-path constants, FSM state and buffer entry types
package mips_pkg;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam int INSTR_BYTES = 4;
  typedef enum logic {RUN, FAULT} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry FIFO of fetched words; head stays put once emptied
module fetch_buf
  import mips_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t e0, e1;
  logic do_pop, wr;
  logic [1:0] c1;
  always_comb begin
    do_pop = pop & (count != 2'd0);
    c1 = count - {1'b0, do_pop};
    wr = push & ~flush;
  end
  // shift only when a second entry exists, so the head keeps its last value when drained
  always_ff @(posedge clock)
    if (!reset_n) begin
      e0 <= '0;
      e1 <= '0;
      count <= 2'd0;
    end else begin
      e0 <= (wr && c1 == 2'd0) ? din : (do_pop && count == 2'd2) ? e1 : e0;
      e1 <= (wr && c1 == 2'd1) ? din : e1;
      count <= flush ? 2'd0 : c1 + {1'b0, wr};
    end
  assign head = e0;
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: drives the synchronous IM, buffers tagged words and hands them to decode
module fetch_controller
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int IM_SIZE = 1024,
  parameter int BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault
);
  state_t state;
  logic [31:0] fetch_pc, inflight_pc;
  logic inflight, pop, legal, issue;
  logic [1:0] count;
  fetch_entry_t head, cap;
  always_comb begin
    pop = out_valid & out_ready;
    legal = fetch_pc[1:0] == 2'b00 && fetch_pc <= 32'(IM_SIZE - INSTR_BYTES);
    issue = state == RUN && !redirect_valid && legal &&
            ({1'b0, count} + {2'b0, inflight} - {2'b0, pop}) < 3'(BUF_DEPTH);
  end
  assign cap = '{pc: inflight_pc, instr: im_instr};
  assign im_addr = fetch_pc;
  assign out_valid = count != 2'd0;
  assign out_instr = head.instr;
  assign out_pc = head.pc;
  fetch_buf u_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (inflight & ~redirect_valid),
    .pop     (pop),
    .flush   (redirect_valid),
    .din     (cap),
    .head    (head),
    .count   (count)
  );
  // redirect squashes the in-flight read; an illegal pc parks the fetcher until redirected
  always_ff @(posedge clock)
    if (!reset_n) begin
      state <= RUN;
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
      fault <= 1'b0;
    end else if (redirect_valid) begin
      state <= RUN;
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      fault <= 1'b0;
    end else if (state == RUN && !legal) begin
      state <= FAULT;
      inflight <= 1'b0;
      fault <= 1'b1;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
      end
    end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: randomized scoreboard bench; expected pc stream rebuilt on every reset/redirect
module tb_fetch_controller;
  localparam int IM_SIZE = 1024;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic clock = 0, reset_n = 0, redirect_valid = 0, out_ready = 1;
  logic [31:0] redirect_pc = 0, im_addr, im_instr, out_instr, out_pc;
  logic out_valid, fault;
  int checks = 0, failures = 0, pops = 0;
  logic [31:0] exp_q[$];
  logic hold = 0;
  logic [31:0] hold_pc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) im_instr <= im_addr;

  fetch_controller #(.RESET_PC(RESET_PC), .IM_SIZE(IM_SIZE), .BUF_DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n), .im_addr(im_addr), .im_instr(im_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fault(fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // every legal word from target upward is what decode should see, in order
  function automatic void restart(input logic [31:0] target);
    exp_q.delete();
    if (target[1:0] == 2'b00)
      for (longint a = target; a <= IM_SIZE - 4; a += 4) exp_q.push_back(32'(a));
  endfunction

  always @(negedge clock) begin
    if (hold) begin
      check("stall_valid", out_valid, 1);
      check("stall_pc", out_pc, hold_pc);
    end
    hold = reset_n & ~redirect_valid & out_valid & ~out_ready;
    hold_pc = out_pc;
    if (reset_n && out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual=%h required=none", out_pc);
      end else check("out_pc", out_pc, exp_q.pop_front());
      check("out_instr", out_instr, out_pc);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1;
    redirect_pc = t;
    step();
    redirect_valid = 0;
    restart(t);
  endtask

  task automatic do_reset();
    reset_n = 0;
    step();
    reset_n = 1;
    restart(RESET_PC);
  endtask

  initial begin
    int p0, r;
    logic [31:0] t;
    step();
    step();
    check("rst_valid", out_valid, 0);
    check("rst_pc", out_pc, 0);
    check("rst_instr", out_instr, 0);
    check("rst_fault", fault, 0);
    check("rst_addr", im_addr, RESET_PC);
    restart(RESET_PC);
    reset_n = 1;
    step();
    check("lat_early", out_valid, 0);
    step();
    check("lat_valid", out_valid, 1);
    check("lat_pc", out_pc, RESET_PC);
    p0 = pops;
    for (int i = 0; i < 8; i++) step();
    check("throughput", 32'(pops - p0), 8);
    out_ready = 0;
    for (int i = 0; i < 5; i++) step();
    check("stall_addr", im_addr, out_pc + 8);
    out_ready = 1;
    for (int i = 0; i < 3; i++) step();
    out_ready = 0;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1;
    redirect(32'h100);
    check("redir_flush", out_valid, 0);
    step();
    check("redir_gap", out_valid, 0);
    step();
    check("redir_valid", out_valid, 1);
    check("redir_pc", out_pc, 32'h100);
    for (int i = 0; i < 4; i++) step();
    redirect(32'h102);
    check("bad_fault_e", fault, 0);
    step();
    check("bad_fault", fault, 1);
    for (int i = 0; i < 4; i++) step();
    check("bad_noissue", out_valid, 0);
    check("bad_addr", im_addr, 32'h102);
    redirect(32'h20);
    check("clr_fault", fault, 0);
    step();
    step();
    check("clr_valid", out_valid, 1);
    check("clr_pc", out_pc, 32'h20);
    redirect(32'd1000);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
    check("end_drained", 32'(exp_q.size()), 0);
    step();
    step();
    check("end_fault", fault, 1);
    check("end_valid", out_valid, 0);
    redirect(32'h0);
    for (int i = 0; i < 6; i++) step();
    do_reset();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_fault", fault, 0);
    check("mid_rst_addr", im_addr, RESET_PC);
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom % 4) != 0;
      r = $urandom % 100;
      if (r == 0) do_reset();
      else if (r < 3) begin
        t = ($urandom % 2) ? 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3))
                           : 32'(IM_SIZE) + 32'($urandom_range(0, 63)) * 4;
        redirect(t);
        step();
        check("rand_fault", fault, 1);
      end else if (r < 6) redirect(32'($urandom_range(0, 255)) * 4);
      else step();
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
